// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller state encoding and the strobe bundle
// driven onto the pipeline registers.
package cpu_types_pkg;

    typedef enum logic [1:0] {PC_RUN, PC_DWAIT, PC_HALT} pctrl_state_t;

    // en[0]/flush[0] belong to IF/ID, en[3] to MEM/WB.
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [2:0] flush;
    } pctrl_strobe_t;

    localparam logic [2:0] FLUSH_IFID = 3'b001;
    localparam logic [2:0] FLUSH_IDEX = 3'b010;
    localparam logic [3:0] EN_ALL     = 4'b1111;
    localparam logic [3:0] EN_HOLD_ID = 4'b1110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall/flush statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-latch enable/flush strobes and PC write enable from
// memory handshakes, load-use hazards, redirects and halt; plus perf counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             ex_load,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             jump_ex,
    input  logic             branch_mem,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             en_1,
    output logic             en_2,
    output logic             en_3,
    output logic             en_4,
    output logic             flush_1,
    output logic             flush_2,
    output logic             flush_3,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t  state_q, state_d;
    logic          halted_q;
    pctrl_strobe_t strb;
    logic          d_stall, lu, redir;
    logic          stall_inc, flush_inc;

    assign d_stall = mem_req & ~dhit;
    assign lu      = ex_load & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign redir   = branch_mem | jump_ex;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        strb      = '0;
        state_d   = state_q;
        flush_inc = 1'b0;
        if (RST) begin
            state_d = PC_RUN;
        end else if ((state_q == PC_HALT) || halt_wb) begin
            state_d = PC_HALT;
        end else if (d_stall || ((state_q == PC_DWAIT) && !dhit)) begin
            // Redirects seen while waiting are held by the frozen latches.
            state_d = PC_DWAIT;
        end else begin
            state_d = PC_RUN;
            if (redir) begin
                strb.pc_en = 1'b1;
                strb.en    = EN_ALL;
                strb.flush = {branch_mem, 2'b11};
                flush_inc  = 1'b1;
            end else if (state_q == PC_DWAIT) begin
                // Release: the fetch lost arbitration to the data access.
                strb.en    = EN_ALL;
                strb.flush = FLUSH_IFID;
            end else if (lu) begin
                strb.en    = EN_HOLD_ID;
                strb.flush = FLUSH_IDEX;
            end else if (!ihit) begin
                strb.en    = EN_ALL;
                strb.flush = FLUSH_IFID;
            end else begin
                strb.en    = EN_ALL;
                strb.pc_en = 1'b1;
            end
        end
    end

    assign stall_inc = ~RST & (state_q != PC_HALT) & ~halt_wb & ~strb.pc_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= PC_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == PC_HALT);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .clr   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clr   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign pc_en   = strb.pc_en;
    assign en_1    = strb.en[0];
    assign en_2    = strb.en[1];
    assign en_3    = strb.en[2];
    assign en_4    = strb.en[3];
    assign flush_1 = strb.flush[0];
    assign flush_2 = strb.flush[1];
    assign flush_3 = strb.flush[2];
    assign halted  = halted_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a rule-level model;
// a second 4-bit-counter instance exercises counter saturation.
module tb_pipeline_ctrl;

    localparam int M_RUN   = 0;
    localparam int M_DWAIT = 1;
    localparam int M_HALT  = 2;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, mem_req, ex_load, id_uses_rt;
    logic        jump_ex, branch_mem, halt_wb;
    logic [4:0]  ex_rt, id_rs, id_rt;

    logic        pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_en_1, s_en_2, s_en_3, s_en_4;
    logic        s_flush_1, s_flush_2, s_flush_3, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int     m_mode   = M_RUN;
    bit     m_halted = 1'b0;
    longint m_stall  = 0;
    longint m_flush  = 0;

    pipeline_ctrl u_dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_load(ex_load), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .jump_ex(jump_ex), .branch_mem(branch_mem),
        .halt_wb(halt_wb), .pc_en(pc_en), .en_1(en_1), .en_2(en_2), .en_3(en_3),
        .en_4(en_4), .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3),
        .halted(halted), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_load(ex_load), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .jump_ex(jump_ex), .branch_mem(branch_mem),
        .halt_wb(halt_wb), .pc_en(s_pc_en), .en_1(s_en_1), .en_2(s_en_2),
        .en_3(s_en_3), .en_4(s_en_4), .flush_1(s_flush_1), .flush_2(s_flush_2),
        .flush_3(s_flush_3), .halted(s_halted), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    // Applies the priority rules to the current inputs and model state.
    // Strobe vector layout: {pc_en, en_4..en_1, flush_3..flush_1}.
    task automatic predict(output logic [7:0] strb, output int nxt,
                           output bit s_inc, output bit f_inc);
        bit dst, lu, redir, pc;
        bit [3:0] en;
        bit [2:0] fl;
        dst   = mem_req && !dhit;
        lu    = ex_load && (ex_rt != 0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        redir = branch_mem || jump_ex;
        pc = 1'b0; en = '0; fl = '0; f_inc = 1'b0; nxt = m_mode;
        if (RST) begin
            nxt = M_RUN;
        end else if (m_mode == M_HALT || halt_wb) begin
            nxt = M_HALT;
        end else if (dst || (m_mode == M_DWAIT && !dhit)) begin
            nxt = M_DWAIT;
        end else begin
            nxt = M_RUN;
            if (m_mode == M_DWAIT) begin
                en = 4'hf; fl[0] = 1'b1;
            end
            if (redir) begin
                pc = 1'b1; en = 4'hf; fl[0] = 1'b1; fl[1] = 1'b1; fl[2] = branch_mem;
                f_inc = 1'b1;
            end else if (m_mode != M_DWAIT) begin
                if (lu) begin
                    en = 4'b1110; fl[1] = 1'b1;
                end else if (!ihit) begin
                    en = 4'hf; fl[0] = 1'b1;
                end else begin
                    en = 4'hf; pc = 1'b1;
                end
            end
        end
        s_inc = !RST && (nxt != M_HALT) && !pc;
        strb  = {pc, en, fl};
    endtask

    // One clock: check strobes mid-cycle, advance model on the edge, check registers.
    task automatic cycle();
        logic [7:0] exp_strb;
        int         nxt;
        bit         s_inc, f_inc;
        @(negedge CLK);
        predict(exp_strb, nxt, s_inc, f_inc);
        check("strobes", {pc_en, en_4, en_3, en_2, en_1, flush_3, flush_2, flush_1}, exp_strb);
        @(posedge CLK);
        if (RST) begin
            m_mode = M_RUN; m_halted = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            m_mode   = nxt;
            m_halted = (nxt == M_HALT);
            m_stall  = m_stall + longint'(s_inc);
            m_flush  = m_flush + longint'(f_inc);
        end
        #1;
        check("state",     state,       m_mode);
        check("halted",    halted,      m_halted);
        check("stall_cnt", stall_cnt,   m_stall);
        check("flush_cnt", flush_cnt,   m_flush);
        check("stall_sat", s_stall_cnt, sat4(m_stall));
        check("flush_sat", s_flush_cnt, sat4(m_flush));
    endtask

    task automatic set_idle();
        RST = 0; ihit = 1; dhit = 1; mem_req = 0; ex_load = 0; ex_rt = 0;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; jump_ex = 0; branch_mem = 0; halt_wb = 0;
    endtask

    task automatic do_reset(input int n);
        RST = 1;
        repeat (n) cycle();
        RST = 0;
    endtask

    initial begin
        set_idle();
        do_reset(2);
        repeat (2) cycle();
        check("run_after_reset", {state, pc_en, en_1, en_4}, {2'd0, 3'b111});

        // Data stall for three cycles, then release
        mem_req = 1; dhit = 0;
        repeat (3) cycle();
        check("dwait_state", state, 2'd1);
        dhit = 1;
        cycle();
        check("stall_after_release", stall_cnt, 32'd4);
        set_idle();
        cycle();

        // Redirect raised while waiting is deferred to the release cycle
        mem_req = 1; dhit = 0; branch_mem = 1;
        repeat (2) cycle();
        dhit = 1;
        cycle();
        set_idle();
        cycle();

        // Load-use on rs, then on rt, then with rt=0
        ex_load = 1; ex_rt = 5; id_rs = 5;
        cycle();
        id_rs = 3; id_rt = 5; id_uses_rt = 1;
        cycle();
        id_uses_rt = 0;
        cycle();
        ex_rt = 0; id_rs = 0;
        cycle();
        set_idle();

        // Branch with fetch miss, then jump alone
        branch_mem = 1; ihit = 0;
        cycle();
        check("flush_after_branch", flush_cnt, 32'd2);
        set_idle(); jump_ex = 1;
        cycle();
        set_idle();

        // Halt coincident with a data stall, held for ten cycles, then reset
        halt_wb = 1; mem_req = 1; dhit = 0;
        cycle();
        set_idle();
        repeat (10) cycle();
        check("halt_sticky", {halted, state}, {1'b1, 2'd2});
        do_reset(1);
        cycle();

        // Saturation of the 4-bit counter
        ihit = 0;
        repeat (16) cycle();
        check("stall_saturated", s_stall_cnt, 4'd15);
        cycle();
        set_idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 99) == 0);
            halt_wb    = ($urandom_range(0, 59) == 0);
            ihit       = ($urandom_range(0, 3) != 0);
            dhit       = ($urandom_range(0, 2) != 0);
            mem_req    = ($urandom_range(0, 2) == 0);
            ex_load    = $urandom_range(0, 1);
            ex_rt      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = $urandom_range(0, 1);
            jump_ex    = ($urandom_range(0, 7) == 0);
            branch_mem = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
